vga_sprite_bouncer: RTL

- Parametrised motion engine for the VGA screensaver. Generalises the single-logo bounce to NUM_SPRITES independent sprites, with a configurable screen size, sprite size and speed.
- Once per frame, on frame_tick from the VGA timing generator, it walks all sprites sequentially. For each one it advances the position, reflects it off the screen edges and cycles its colour index on each bounce.
- Outputs are registered and are stable for the rest of the frame. The pixel renderer reads them.

---
 rtl/vga_sprite_bouncer_if.sv | 28 ++
 rtl/vga_sprite_bouncer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_bouncer_if.sv
// Bus bundle for vga_sprite_bouncer: frame control in, per-sprite motion state out.
// Positions, colours and bounce flags are packed with sprite i at slice i.
interface vga_sprite_bouncer_if #(
  parameter int NUM_SPRITES = 2,
  parameter int POS_W       = 10,
  parameter int COLOR_W     = 3
);
  logic                           frame_tick;
  logic                           pause;
  logic [1:0]                     speed;
  logic [NUM_SPRITES*POS_W-1:0]   x_out;
  logic [NUM_SPRITES*POS_W-1:0]   y_out;
  logic [NUM_SPRITES*COLOR_W-1:0] color_out;
  logic [NUM_SPRITES-1:0]         bounce;
  logic                           busy;
  logic                           overrun;
  logic                           collide;

  modport master (
    output frame_tick, pause, speed,
    input  x_out, y_out, color_out, bounce, busy, overrun, collide
  );

  modport slave (
    input  frame_tick, pause, speed,
    output x_out, y_out, color_out, bounce, busy, overrun, collide
  );
endinterface

// File: rtl/vga_sprite_bouncer.sv
// Per-frame motion engine: walks NUM_SPRITES sprites one per cycle, bouncing them off the
// screen edges. Optional sprite-overlap detection is enabled by defining SPRITE_COLLIDE_EN.
module vga_sprite_bouncer #(
  parameter int NUM_SPRITES = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SPR_W       = 128,
  parameter int SPR_H       = 64,
  parameter int POS_W       = 10,
  parameter int COLOR_W     = 3
) (
  input logic                 clk,
  input logic                 rst,
  vga_sprite_bouncer_if.slave bus
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [POS_W:0] XMAX = (POS_W+1)'(H_ACTIVE - SPR_W);
  localparam logic [POS_W:0] YMAX = (POS_W+1)'(V_ACTIVE - SPR_H);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [2:0]             step_q, step_d;
  logic [POS_W-1:0]       x_q [NUM_SPRITES];
  logic [POS_W-1:0]       x_d [NUM_SPRITES];
  logic [POS_W-1:0]       y_q [NUM_SPRITES];
  logic [POS_W-1:0]       y_d [NUM_SPRITES];
  logic [COLOR_W-1:0]     color_q [NUM_SPRITES];
  logic [COLOR_W-1:0]     color_d [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] dx_neg_q, dx_neg_d;
  logic [NUM_SPRITES-1:0] dy_neg_q, dy_neg_d;
  logic [NUM_SPRITES-1:0] hit_q, hit_d;
  logic [NUM_SPRITES-1:0] bounce_q, bounce_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic [POS_W+1:0]       x_res, y_res;

`ifdef SPRITE_COLLIDE_EN
  localparam logic [POS_W:0] SW = (POS_W+1)'(SPR_W);
  localparam logic [POS_W:0] SH = (POS_W+1)'(SPR_H);

  logic                   collide_q, collide_d;
  logic [NUM_SPRITES-1:0] ov;

  function automatic logic boxes_overlap(
    input logic [POS_W-1:0] a,
    input logic [POS_W-1:0] b,
    input logic [POS_W:0]   size
  );
    return ({1'b0, a} < ({1'b0, b} + size)) && ({1'b0, b} < ({1'b0, a} + size));
  endfunction
`endif

  // Result packing: {bounced, new_dir_negative, new_position}.
  function automatic logic [POS_W+1:0] axis_next(
    input logic [POS_W-1:0] pos,
    input logic             neg,
    input logic [2:0]       step,
    input logic [POS_W:0]   lim
  );
    logic [POS_W:0] wide;
    logic [POS_W:0] stp;
    logic [POS_W:0] nxt;
    logic           hit;
    logic           n;
    wide = {1'b0, pos};
    stp  = (POS_W+1)'(step);
    hit  = 1'b0;
    n    = neg;
    if (!neg) begin
      nxt = wide + stp;
      if (nxt >= lim) begin
        nxt = lim;
        n   = 1'b1;
        hit = 1'b1;
      end
    end else if (wide <= stp) begin
      nxt = '0;
      n   = 1'b0;
      hit = 1'b1;
    end else begin
      nxt = wide - stp;
    end
    return {hit, n, nxt[POS_W-1:0]};
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    step_d    = step_q;
    x_d       = x_q;
    y_d       = y_q;
    color_d   = color_q;
    dx_neg_d  = dx_neg_q;
    dy_neg_d  = dy_neg_q;
    hit_d     = hit_q;
    overrun_d = overrun_q;
    x_res     = '0;
    y_res     = '0;
`ifdef SPRITE_COLLIDE_EN
    collide_d = collide_q;
    ov        = '0;
`endif

    // A tick that lands anywhere outside IDLE is lost; record it.
    if (bus.frame_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.frame_tick && !bus.pause) begin
          state_d = UPDATE;
          idx_d   = '0;
          step_d  = {1'b0, bus.speed} + 3'd1;
          hit_d   = '0;
        end
      end

      UPDATE: begin
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            x_res       = axis_next(x_q[i], dx_neg_q[i], step_q, XMAX);
            y_res       = axis_next(y_q[i], dy_neg_q[i], step_q, YMAX);
            x_d[i]      = x_res[POS_W-1:0];
            y_d[i]      = y_res[POS_W-1:0];
            dx_neg_d[i] = x_res[POS_W];
            dy_neg_d[i] = y_res[POS_W];
            if (x_res[POS_W+1] || y_res[POS_W+1]) begin
              color_d[i] = color_q[i] + COLOR_W'(1);
              hit_d[i]   = 1'b1;
            end
          end
        end
        if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
`ifdef SPRITE_COLLIDE_EN
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
          for (int unsigned j = i + 1; j < NUM_SPRITES; j++) begin
            if (boxes_overlap(x_q[i], x_q[j], SW) && boxes_overlap(y_q[i], y_q[j], SH)) begin
              ov[i] = 1'b1;
              ov[j] = 1'b1;
            end
          end
        end
        collide_d = |ov;
        if (collide_d && !collide_q) begin
          for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (ov[i]) begin
              color_d[i] = color_q[i] + COLOR_W'(1);
            end
          end
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    // Registered so that busy falls and bounce pulses in the same cycle the FSM sits in DONE.
    busy_d   = (state_d == UPDATE);
    bounce_d = (state_d == DONE) ? hit_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      step_q    <= '0;
      dx_neg_q  <= '0;
      dy_neg_q  <= '0;
      hit_q     <= '0;
      bounce_q  <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]     <= POS_W'(i * 16);
        y_q[i]     <= POS_W'(i * 8);
        color_q[i] <= COLOR_W'(i);
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      step_q    <= step_d;
      dx_neg_q  <= dx_neg_d;
      dy_neg_q  <= dy_neg_d;
      hit_q     <= hit_d;
      bounce_q  <= bounce_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      x_q       <= x_d;
      y_q       <= y_d;
      color_q   <= color_d;
    end
  end

`ifdef SPRITE_COLLIDE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      collide_q <= 1'b0;
    end else begin
      collide_q <= collide_d;
    end
  end

  assign bus.collide = collide_q;
`else
  assign bus.collide = 1'b0;
`endif

  always_comb begin
    bus.x_out     = '0;
    bus.y_out     = '0;
    bus.color_out = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      bus.x_out[i*POS_W +: POS_W]       = x_q[i];
      bus.y_out[i*POS_W +: POS_W]       = y_q[i];
      bus.color_out[i*COLOR_W +: COLOR_W] = color_q[i];
    end
  end

  assign bus.bounce  = bounce_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule
